llc_burst_adaptor: RTL and testbench

Memory-side responder for the cache's `pmem` interface. It accepts one 256-bit cacheline read or write request from the cache controller/datapath, addressed by `pmem_address`. It converts the request into a 4-beat, 64-bit burst transaction toward physical memory and signals completion to the cache with a single-cycle `pmem_resp`. It sits between the cache datapath's `pmem_rdata`/`pmem_wdata`/`pmem_address` ports and the DRAM/memory model.

---
 rtl/llc_burst_adaptor_if.sv | 36 +++
 rtl/llc_burst_adaptor.sv | 106 ++++++++++
 tb/tb_llc_burst_adaptor.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/llc_burst_adaptor_if.sv
// llc_burst_adaptor_if
//   Bundles the cache-side pmem port and the memory-side burst port of
//   llc_burst_adaptor.
//   slave  : the adaptor's view (takes cache requests and memory beats,
//            drives the assembled line, resp pulse and burst requests).
//   master : the surrounding system's view (cache + memory model).
//   Cache side : pmem_read, pmem_write, pmem_address, pmem_wdata,
//                pmem_rdata, pmem_resp
//   Memory side: burst_i, burst_o, address_o, read_o, write_o, resp_i
interface llc_burst_adaptor_if #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
);
  logic                pmem_read;
  logic                pmem_write;
  logic [31:0]         pmem_address;
  logic [s_line-1:0]   pmem_wdata;
  logic [s_line-1:0]   pmem_rdata;
  logic                pmem_resp;
  logic [s_burst-1:0]  burst_i;
  logic [s_burst-1:0]  burst_o;
  logic [31:0]         address_o;
  logic                read_o;
  logic                write_o;
  logic                resp_i;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, resp_i,
    output pmem_rdata, pmem_resp, burst_o, address_o, read_o, write_o
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_i, resp_i,
    input  pmem_rdata, pmem_resp, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/llc_burst_adaptor.sv
// llc_burst_adaptor
//   Memory-side responder for the cache pmem port. A 256-bit line read or
//   write is turned into a 4-beat 64-bit burst toward memory; completion is
//   reported to the cache with a one-cycle pmem_resp.
//   Ports:
//     clk  : single clock, posedge
//     rst  : synchronous, active-high reset
//     bus  : llc_burst_adaptor_if.slave (cache pmem port + memory burst port)
module llc_burst_adaptor #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  llc_burst_adaptor_if.slave   bus
);

  localparam int unsigned BEATS = s_line / s_burst;
  localparam int unsigned CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic [31:0]                    addr_q;
  logic [BEATS-1:0][s_burst-1:0]  line_q;
  logic [BEATS-1:0][s_burst-1:0]  rdata_q;
  logic                           read_q;
  logic                           write_q;
  logic                           resp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Write has priority when both requests are present.
          if (bus.pmem_write) begin
            addr_q  <= {bus.pmem_address[31:5], 5'b0};
            line_q  <= bus.pmem_wdata;
            cnt_q   <= '0;
            write_q <= 1'b1;
            state_q <= WR;
          end else if (bus.pmem_read) begin
            addr_q  <= {bus.pmem_address[31:5], 5'b0};
            cnt_q   <= '0;
            read_q  <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            rdata_q[cnt_q] <= bus.burst_i;
            cnt_q          <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WR: begin
          if (bus.resp_i) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // read_q/write_q are high exactly while in RD/WR, so they gate the
  // address and the write beat without decoding the state again.
  assign bus.address_o  = (read_q || write_q) ? addr_q : '0;
  assign bus.burst_o    = write_q ? line_q[cnt_q] : '0;
  assign bus.read_o     = read_q;
  assign bus.write_o    = write_q;
  assign bus.pmem_resp  = resp_q;
  assign bus.pmem_rdata = rdata_q;

endmodule

// File: tb/tb_llc_burst_adaptor.sv
module tb_llc_burst_adaptor;

  logic clk;
  logic rst;

  llc_burst_adaptor_if #(.s_line(256), .s_burst(64)) bus ();

  llc_burst_adaptor #(.s_line(256), .s_burst(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] rdata;
  } txn_t;

  txn_t         exp_q[$];
  logic [63:0]  wbeat_q[$];
  logic [255:0] last_rd;
  int           vectors;
  int           miscompares;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected transaction when a burst starts and checks
  // beats and the completion against it.
  bit   active;
  txn_t cur;
  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
    end else begin
      if ((bus.read_o || bus.write_o) && !active) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_burst", {bus.read_o, bus.write_o}, '0);
        end else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          chk("burst_addr", bus.address_o, cur.addr);
        end
      end
      if (active) begin
        if (bus.read_o || bus.write_o) begin
          chk("read_o_level", bus.read_o, cur.rd);
          chk("write_o_level", bus.write_o, !cur.rd);
          if (bus.resp_i) begin
            chk("beat_addr", bus.address_o, cur.addr);
            if (bus.write_o) begin
              if (wbeat_q.size() == 0) chk("unexpected_wr_beat", bus.write_o, 1'b0);
              else chk("wr_beat", bus.burst_o, wbeat_q.pop_front());
            end
          end
        end
        if (bus.pmem_resp) begin
          chk("rdata_at_resp", bus.pmem_rdata, cur.rdata);
          chk("no_req_at_resp", {bus.read_o, bus.write_o}, '0);
          active = 1'b0;
        end
      end else if (bus.pmem_resp) begin
        chk("unexpected_resp", bus.pmem_resp, 1'b0);
      end
    end
  end

  // One complete transfer; pat bit n gives resp_i in the n-th burst cycle.
  task automatic xfer(input bit wr, input bit both, input logic [31:0] addr,
                      input logic [31:0] exp_addr, input logic [255:0] line,
                      input logic [15:0] pat);
    txn_t        t;
    int          beats;
    int          cyc;
    logic [63:0] sl[4];
    for (int i = 0; i < 4; i++) sl[i] = line[i*64 +: 64];
    t.rd    = !wr;
    t.addr  = exp_addr;
    t.rdata = wr ? last_rd : line;
    exp_q.push_back(t);
    if (wr) begin
      for (int i = 0; i < 4; i++) wbeat_q.push_back(sl[i]);
    end else begin
      last_rd = line;
    end
    @(posedge clk); #1;
    bus.pmem_read    = !wr || both;
    bus.pmem_write   = wr;
    bus.pmem_address = addr;
    bus.pmem_wdata   = wr ? line : ~line;
    chk("idle_before_req", {bus.read_o, bus.write_o, bus.pmem_resp}, '0);
    @(posedge clk); #1;
    // Inputs change after acceptance; the latched values must be used.
    bus.pmem_address = ~addr;
    bus.pmem_wdata   = ~line;
    chk("dir_after_accept", {bus.read_o, bus.write_o}, {!wr, wr});
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 32) begin
      bus.resp_i  = (cyc < 16) ? pat[cyc] : 1'b1;
      bus.burst_i = (bus.resp_i && !wr) ? sl[beats] : 64'hDEAD_BEEF_0BAD_F00D;
      if (bus.resp_i) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.resp_i = 1'b0;
    chk("resp_pulse", bus.pmem_resp, 1'b1);
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    vectors     = 0;
    miscompares = 0;
    last_rd     = '0;
    active      = 1'b0;
    rst              = 1'b1;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.burst_i      = '0;
    bus.resp_i       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ctl", {bus.read_o, bus.write_o, bus.pmem_resp}, '0);
    chk("reset_addr", bus.address_o, 32'h0);
    chk("reset_burst_o", bus.burst_o, 64'h0);
    chk("reset_rdata", bus.pmem_rdata, '0);

    // Idle with resp_i toggling: nothing may move.
    for (int i = 0; i < 6; i++) begin
      bus.resp_i  = i[0];
      bus.burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("idle_outputs", {bus.read_o, bus.write_o, bus.pmem_resp, bus.address_o, bus.burst_o}, '0);
      chk("idle_rdata", bus.pmem_rdata, '0);
    end
    bus.resp_i = 1'b0;

    // Read, four consecutive beats: resp 5 cycles after acceptance.
    xfer(1'b0, 1'b0, 32'h0000_1234, 32'h0000_1220,
         {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 16'hFFFF);
    idle(2);

    // Write with resp_i gaps 1,0,1,0,1,1.
    xfer(1'b1, 1'b0, 32'h8000_0040, 32'h8000_0040,
         {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 16'hFFF5);
    idle(2);

    // Both requests high: write wins, read_o never rises.
    xfer(1'b1, 1'b1, 32'h0000_011F, 32'h0000_0100,
         {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0}, 16'hFFFF);
    idle(2);

    // Reset after two read beats.
    t.rd    = 1'b1;
    t.addr  = 32'h0000_2000;
    t.rdata = '0;
    exp_q.push_back(t);
    @(posedge clk); #1;
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'h0000_2000;
    @(posedge clk); #1;
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'h9999_0000_9999_0001;
    @(posedge clk); #1;
    bus.burst_i = 64'h9999_0000_9999_0002;
    @(posedge clk); #1;
    bus.resp_i    = 1'b0;
    bus.pmem_read = 1'b0;
    rst           = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ctl", {bus.read_o, bus.write_o, bus.pmem_resp}, '0);
    chk("abort_addr", bus.address_o, 32'h0);
    chk("abort_rdata", bus.pmem_rdata, '0);
    last_rd = '0;
    idle(1);

    // Full read after reset: beats must land from slot 0 again.
    xfer(1'b0, 1'b0, 32'h0000_2008, 32'h0000_2000,
         {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
          64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001}, 16'hFFFF);
    idle(1);

    // Back-to-back read then write (one IDLE cycle in between).
    xfer(1'b0, 1'b0, 32'h0000_0040, 32'h0000_0040,
         {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
          64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001}, 16'hFFFB);
    xfer(1'b1, 1'b0, 32'h0000_0060, 32'h0000_0060,
         {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
          64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001}, 16'hFFFF);
    idle(1);
    chk("rdata_after_write", bus.pmem_rdata,
        {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
         64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001});
    idle(2);

    chk("txn_queue_drained", exp_q.size(), 0);
    chk("wbeat_queue_drained", wbeat_q.size(), 0);
    chk("monitor_idle", active, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
